seq_gen: RTL and testbench
==========================

Name: seq_gen

Overview:
- Parametrised successor to the 64-bit enabled sequence generator.
- Produces a W-bit registered sequence on `y`, advancing one term per enabled cycle.
- Selectable modes: count up, count down, Fibonacci, shift-add.
- Adds parallel load, wrap/saturate control, a sticky overflow flag, an update-valid pulse and an update counter.
- Sits as a stimulus/pattern source feeding datapath blocks and as a self-checking reference in benches.

Parameters:
W, 64, width of sequence output `y` and internal previous-term register (W >= 4)
SW, 16, width of step input (SW <= W; zero-extended to W)
CW, 32, width of update counter `cnt` (wraps silently)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
en  input  1  advance sequence by one term this cycle
ld  input  1  load `ld_val` into `y` this cycle (priority over `en`)
ld_val  input  W  load value
mode  input  2  0=up, 1=down, 2=Fibonacci, 3=shift-add
step  input  SW  increment/decrement/addend for modes 0, 1, 3
sat  input  1  1=saturate on overflow, 0=wrap modulo 2^W
y  output  W  current sequence term (registered)
valid  output  1  one-cycle pulse: `y` was updated by an enabled step last edge
ovf  output  1  sticky: an enabled step over/underflowed since last rst/ld
cnt  output  CW  number of enabled steps since last rst/ld

Behaviour:
- Priority per edge: rst > ld > en > hold.
- Reset (synchronous, edge with rst=1):
  - y=0, prev=1, valid=0, ovf=0, cnt=0.
  - Applies mid-sequence with no residue: the next en after reset restarts all modes from y=0, prev=1.
- Load (ld=1, rst=0):
  - y=ld_val, prev=0, ovf=0, cnt=0, valid=0.
  - en ignored that cycle.
- Enabled step (en=1, ld=0, rst=0):
  - Compute a W+1-bit result r from current y, prev, step:
    - mode 0: r = y + step
    - mode 1: r = y - step; underflow when step > y
    - mode 2: r = y + prev
    - mode 3: r = (y << 1) + step; overflow when bit W of y<<1 or the add carries out
  - Overflow = bit W of r (mode 0/2/3) or borrow (mode 1).
  - On overflow: ovf<=1 (sticky).
    - sat=0: y <= r[W-1:0] (wrap).
    - sat=1: y <= all-ones (modes 0/2/3) or 0 (mode 1).
  - Always on step: prev <= old y, cnt <= cnt+1 (mod 2^CW), valid <= 1.
- Idle (en=0, ld=0): y, prev, ovf, cnt hold; valid <= 0.
- Latency: y reflects a step one edge after en sampled high; valid is coincident with the new y.
- Back-to-back en: one term per cycle, no bubbles.
- Mode, step and sat are sampled only on enabled edges. A change takes effect on the next step, using the existing prev (prev tracks last y in every mode, so switching to mode 2 continues from the last two terms).
- Fibonacci from reset gives y = F(k) after k steps: 0 → 1, 1, 2, 3, 5, …
- Loaded Fibonacci from v gives v, 2v, 3v, 5v, …
- Saturated value stays pinned on further overflowing steps; ovf stays 1.
- No combinational path from inputs to outputs.

Test Plan:
- W=64, rst 1 cycle, mode=2, en=1 for 100 cycles:
  - y after step k equals F(k), e.g. step 10 → 55, step 50 → 12586269025.
  - Step 94 wraps (F(94) mod 2^64), ovf rises that edge.
  - valid high every cycle; cnt=100 at end.
- W=8, mode=2, sat=0, 14 steps from reset:
  - Steps 1..13 give 1,1,2,…,233 with ovf=0.
  - Step 14 → y=121, ovf=1.
  - Repeat with sat=1 → step 14 y=255, step 15 y=255, ovf stays 1.
- W=8, mode=1, ld=1 ld_val=5, then en with step=3 twice:
  - sat=0: y=2 then y=255, ovf=1.
  - sat=1: second step y=0.
  - Following ld=1 clears ovf=0, cnt=0.
- W=8, mode=0 step=1:
  - en pattern 1,0,1,1,0 → y=1,1,2,3,3; valid=1,0,1,1,0; cnt=3.
  - ld and en together at y=3 with ld_val=40 → y=40, cnt=0, valid=0.
- W=8, mode=3 step=1 from 0: y=1,3,7,15,31,63,127,255; next step → wrap y=255 (510+1 mod 256), ovf=1.
- Mid-sequence: mode 0 step=2 to y=6, switch mode=2 → next y=10 (6+4), then 16. Assert rst during en → y=0, cnt=0, ovf=0; next en with mode=2 gives y=1.

Source files
------------

// File: rtl/seq_gen.sv
// Registered W-bit sequence source (up / down / Fibonacci / shift-add) with load,
// wrap-or-saturate, sticky overflow, update-valid pulse and step counter.
module seq_gen #(
  parameter int W  = 64,
  parameter int SW = 16,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          ld,
  input  logic [W-1:0]  ld_val,
  input  logic [1:0]    mode,
  input  logic [SW-1:0] step,
  input  logic          sat,
  output logic [W-1:0]  y,
  output logic          valid,
  output logic          ovf,
  output logic [CW-1:0] cnt
);

  typedef enum logic [1:0] {
    M_UP    = 2'd0,
    M_DOWN  = 2'd1,
    M_FIB   = 2'd2,
    M_SHADD = 2'd3
  } mode_t;

  logic [W-1:0] prev;
  logic [W-1:0] step_w;
  logic [W:0]   r;
  logic [W+1:0] shsum;
  logic         of_c;
  logic [W-1:0] nxt;

  always_comb begin
    step_w = W'(step);
    // Two spare bits: one for the bit shifted out of y, one for the add carry.
    shsum  = {1'b0, y, 1'b0} + {2'b00, step_w};
    r      = '0;
    of_c   = 1'b0;
    case (mode_t'(mode))
      M_UP: begin
        r    = {1'b0, y} + {1'b0, step_w};
        of_c = r[W];
      end
      M_DOWN: begin
        r    = {1'b0, y} - {1'b0, step_w};
        of_c = r[W];
      end
      M_FIB: begin
        r    = {1'b0, y} + {1'b0, prev};
        of_c = r[W];
      end
      default: begin
        r    = {1'b0, shsum[W-1:0]};
        of_c = |shsum[W+1:W];
      end
    endcase
    nxt = r[W-1:0];
    if (of_c && sat) begin
      nxt = (mode_t'(mode) == M_DOWN) ? '0 : '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y     <= '0;
      prev  <= W'(1);
      valid <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else if (ld) begin
      y     <= ld_val;
      prev  <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else if (en) begin
      y     <= nxt;
      prev  <= y;
      valid <= 1'b1;
      if (of_c) ovf <= 1'b1;
      cnt   <= cnt + CW'(1);
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: a W=64 instance for long Fibonacci runs and a
// W=8 instance for overflow, saturation, load and mode-switch cases.
module tb_seq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, en8, ld8, sat8;
  logic [7:0]  ldv8, step8;
  logic [1:0]  mode8;
  logic [7:0]  y8;
  logic        v8, o8;
  logic [31:0] c8;

  logic        rst64, en64, ld64, sat64;
  logic [63:0] ldv64;
  logic [15:0] step64;
  logic [1:0]  mode64;
  logic [63:0] y64;
  logic        v64, o64;
  logic [31:0] c64;

  seq_gen #(.W(8), .SW(8), .CW(32)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .ld(ld8), .ld_val(ldv8), .mode(mode8),
    .step(step8), .sat(sat8), .y(y8), .valid(v8), .ovf(o8), .cnt(c8)
  );

  seq_gen #(.W(64), .SW(16), .CW(32)) dut64 (
    .clk(clk), .rst(rst64), .en(en64), .ld(ld64), .ld_val(ldv64), .mode(mode64),
    .step(step64), .sat(sat64), .y(y64), .valid(v64), .ovf(o64), .cnt(c64)
  );

  typedef struct {
    bit          d64;
    logic [63:0] y;
    logic        v;
    logic        o;
    logic [31:0] c;
    int          tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input int tag, input string what, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL tag=%0d %s actual=%0d required=%0d", tag, what, act, req);
    end
  endtask

  // Monitor: one expectation is queued per driven cycle; compare just after the edge it applies to.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.d64) begin
          cmp(e.tag, "y",     y64, e.y);
          cmp(e.tag, "valid", {63'd0, v64}, {63'd0, e.v});
          cmp(e.tag, "ovf",   {63'd0, o64}, {63'd0, e.o});
          cmp(e.tag, "cnt",   {32'd0, c64}, {32'd0, e.c});
        end else begin
          cmp(e.tag, "y",     {56'd0, y8}, e.y);
          cmp(e.tag, "valid", {63'd0, v8}, {63'd0, e.v});
          cmp(e.tag, "ovf",   {63'd0, o8}, {63'd0, e.o});
          cmp(e.tag, "cnt",   {32'd0, c8}, {32'd0, e.c});
        end
      end
    end
  end

  task automatic d8(input logic r, input logic e, input logic l, input logic [7:0] lv,
                    input logic [1:0] m, input logic [7:0] st, input logic s);
    rst8 = r; en8 = e; ld8 = l; ldv8 = lv; mode8 = m; step8 = st; sat8 = s;
  endtask

  task automatic d64(input logic r, input logic e, input logic [1:0] m);
    rst64 = r; en64 = e; ld64 = 1'b0; ldv64 = '0; mode64 = m; step64 = '0; sat64 = 1'b0;
  endtask

  task automatic x8(input logic [7:0] ey, input logic ev, input logic eo, input logic [31:0] ec, input int tag);
    exp_t e;
    e.d64 = 1'b0; e.y = {56'd0, ey}; e.v = ev; e.o = eo; e.c = ec; e.tag = tag;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic x64(input logic [63:0] ey, input logic ev, input logic eo, input logic [31:0] ec, input int tag);
    exp_t e;
    e.d64 = 1'b1; e.y = ey; e.v = ev; e.o = eo; e.c = ec; e.tag = tag;
    q.push_back(e);
    @(negedge clk);
  endtask

  logic [7:0]  fb [0:12];
  logic [64:0] nx;
  logic [63:0] fa, fbp, ey64;

  initial begin
    fb = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};
    d8(1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 8'd0, 1'b0);
    d64(1'b1, 1'b0, 2'd2);
    @(negedge clk);

    // W=64 Fibonacci from reset, 100 back-to-back steps.
    d64(1'b1, 1'b0, 2'd2);
    x64(64'd0, 1'b0, 1'b0, 32'd0, 100);
    fa = 64'd0; fbp = 64'd1;
    for (int k = 1; k <= 100; k++) begin
      d64(1'b0, 1'b1, 2'd2);
      nx   = {1'b0, fa} + {1'b0, fbp};
      fbp  = fa;
      fa   = nx[63:0];
      ey64 = (k == 10) ? 64'd55 : (k == 50) ? 64'd12586269025 : fa;
      x64(ey64, 1'b1, (k >= 94), 32'(k), 1000 + k);
    end
    d64(1'b0, 1'b0, 2'd2);
    x64(fa, 1'b0, 1'b1, 32'd100, 1200);

    // W=8 Fibonacci, wrap then saturate.
    for (int s = 0; s < 2; s++) begin
      d8(1'b1, 1'b0, 1'b0, 8'd0, 2'd2, 8'd0, 1'b0);
      x8(8'd0, 1'b0, 1'b0, 32'd0, 200 + s * 100);
      for (int i = 0; i < 13; i++) begin
        d8(1'b0, 1'b1, 1'b0, 8'd0, 2'd2, 8'd0, s[0]);
        x8(fb[i], 1'b1, 1'b0, 32'(i + 1), 201 + s * 100 + i);
      end
      d8(1'b0, 1'b1, 1'b0, 8'd0, 2'd2, 8'd0, s[0]);
      x8((s == 0) ? 8'd121 : 8'd255, 1'b1, 1'b1, 32'd14, 214 + s * 100);
      if (s == 1) x8(8'd255, 1'b1, 1'b1, 32'd15, 315);
    end

    // Count down after load, wrap and saturate, load clears flags.
    d8(1'b0, 1'b0, 1'b1, 8'd5, 2'd1, 8'd3, 1'b0); x8(8'd5,   1'b0, 1'b0, 32'd0, 400);
    d8(1'b0, 1'b1, 1'b0, 8'd0, 2'd1, 8'd3, 1'b0); x8(8'd2,   1'b1, 1'b0, 32'd1, 401);
    x8(8'd255, 1'b1, 1'b1, 32'd2, 402);
    d8(1'b0, 1'b0, 1'b1, 8'd5, 2'd1, 8'd3, 1'b1); x8(8'd5,   1'b0, 1'b0, 32'd0, 403);
    d8(1'b0, 1'b1, 1'b0, 8'd0, 2'd1, 8'd3, 1'b1); x8(8'd2,   1'b1, 1'b0, 32'd1, 404);
    x8(8'd0, 1'b1, 1'b1, 32'd2, 405);
    d8(1'b0, 1'b0, 1'b1, 8'd9, 2'd1, 8'd3, 1'b1); x8(8'd9,   1'b0, 1'b0, 32'd0, 406);

    // Count up with gaps in en, then ld wins over en.
    d8(1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 8'd1, 1'b0); x8(8'd0, 1'b0, 1'b0, 32'd0, 500);
    d8(1'b0, 1'b1, 1'b0, 8'd0, 2'd0, 8'd1, 1'b0); x8(8'd1, 1'b1, 1'b0, 32'd1, 501);
    d8(1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'd1, 1'b0); x8(8'd1, 1'b0, 1'b0, 32'd1, 502);
    d8(1'b0, 1'b1, 1'b0, 8'd0, 2'd0, 8'd1, 1'b0); x8(8'd2, 1'b1, 1'b0, 32'd2, 503);
    x8(8'd3, 1'b1, 1'b0, 32'd3, 504);
    d8(1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'd1, 1'b0); x8(8'd3, 1'b0, 1'b0, 32'd3, 505);
    d8(1'b0, 1'b1, 1'b1, 8'd40, 2'd0, 8'd1, 1'b0); x8(8'd40, 1'b0, 1'b0, 32'd0, 506);

    // Shift-add: 2^k-1 then wrap on the ninth step.
    d8(1'b1, 1'b0, 1'b0, 8'd0, 2'd3, 8'd1, 1'b0); x8(8'd0, 1'b0, 1'b0, 32'd0, 600);
    for (int k = 1; k <= 8; k++) begin
      d8(1'b0, 1'b1, 1'b0, 8'd0, 2'd3, 8'd1, 1'b0);
      x8(8'((1 << k) - 1), 1'b1, 1'b0, 32'(k), 600 + k);
    end
    x8(8'd255, 1'b1, 1'b1, 32'd9, 609);

    // Mode switch mid-sequence keeps prev; reset during en discards residue.
    d8(1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 8'd2, 1'b0); x8(8'd0, 1'b0, 1'b0, 32'd0, 700);
    d8(1'b0, 1'b1, 1'b0, 8'd0, 2'd0, 8'd2, 1'b0); x8(8'd2, 1'b1, 1'b0, 32'd1, 701);
    x8(8'd4, 1'b1, 1'b0, 32'd2, 702);
    x8(8'd6, 1'b1, 1'b0, 32'd3, 703);
    d8(1'b0, 1'b1, 1'b0, 8'd0, 2'd2, 8'd2, 1'b0); x8(8'd10, 1'b1, 1'b0, 32'd4, 704);
    x8(8'd16, 1'b1, 1'b0, 32'd5, 705);
    d8(1'b1, 1'b1, 1'b0, 8'd0, 2'd2, 8'd2, 1'b0); x8(8'd0, 1'b0, 1'b0, 32'd0, 706);
    d8(1'b0, 1'b1, 1'b0, 8'd0, 2'd2, 8'd2, 1'b0); x8(8'd1, 1'b1, 1'b0, 32'd1, 707);

    d8(1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
